// File: rtl/ib_fetch_pkg.sv
// Shared definitions for the instruction-buffer fetch unit: FSM states, IB entry layout, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the IB FIFO depth lives here so producer and consumer agree on it.
package ib_fetch_pkg;

    localparam int          IB_FIFO_DEPTH = 15;
    localparam int          IB_ENTRY_W    = 65;
    localparam int          IB_ADEL_BIT   = 64;
    localparam logic [31:0] IB_RESET_PC   = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_REQ         = 3'd1,
        ST_WAIT        = 3'd2,
        ST_PUSH        = 3'd3,
        ST_CANCEL_REQ  = 3'd4,
        ST_CANCEL_WAIT = 3'd5,
        ST_HALT        = 3'd6
    } fetch_state_t;

    // IB entry: {adel[64], pc[63:32], inst[31:0]}
    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

endpackage

// File: rtl/ib_fetch.sv
// Instruction fetch: issues one bus read at a time from pc and pushes {adel, pc, inst} into the IB FIFO.
// Latency: push two cycles after inst_addr_ok with zero-wait memory; one fetch every 4 cycles.
// Backpressure: fifo_full is only honoured in IDLE, so an accepted request always owns a FIFO slot.
module ib_fetch
    import ib_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IB_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [31:0]           flush_pc,
    output logic                  inst_req,
    output logic [31:0]           inst_addr,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic [31:0]           inst_rdata,
    input  logic                  fifo_full,
    output logic                  fifo_w_en,
    output logic [IB_ENTRY_W-1:0] fifo_in
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  stale_q, stale_d;   // address still owed to the bus after a flush in REQ
    ib_entry_t    entry_q, entry_d;

    // State register; reset wins over everything and abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: fetch pc, stale request address, registered IB entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            stale_q <= '0;
            entry_q <= '0;
        end else begin
            pc_q    <= pc_d;
            stale_q <= stale_d;
            entry_q <= entry_d;
        end
    end

    // Next-state and datapath update; a flush always reloads pc, cancelled responses are drained.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        entry_d = entry_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    pc_d = flush_pc;
                end else if (!fifo_full) begin
                    if (pc_q[1:0] != 2'b00) begin
                        entry_d = '{adel: 1'b1, pc: pc_q, inst: 32'h0};
                        state_d = ST_PUSH;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush) begin
                    pc_d = flush_pc;
                    if (inst_addr_ok) begin
                        state_d = ST_CANCEL_WAIT;
                    end else begin
                        // Bus protocol requires the un-accepted address to stay put.
                        stale_d = pc_q;
                        state_d = ST_CANCEL_REQ;
                    end
                end else if (inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = inst_data_ok ? ST_IDLE : ST_CANCEL_WAIT;
                end else if (inst_data_ok) begin
                    entry_d = '{adel: 1'b0, pc: pc_q, inst: inst_rdata};
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = ST_IDLE;
                end else begin
                    state_d = entry_q.adel ? ST_HALT : ST_IDLE;
                end
            end
            ST_CANCEL_REQ: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (inst_addr_ok) begin
                    state_d = inst_data_ok ? ST_IDLE : ST_CANCEL_WAIT;
                end
            end
            ST_CANCEL_WAIT: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (inst_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign inst_req  = !rst && ((state_q == ST_REQ) || (state_q == ST_CANCEL_REQ));
    assign inst_addr = (state_q == ST_CANCEL_REQ) ? stale_q : pc_q;
    assign fifo_w_en = !rst && !flush && (state_q == ST_PUSH);
    assign fifo_in   = entry_q;

endmodule
